// File: rtl/alu_seq_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pipe_if
// Brief    : Issue and result handshake bundle between decode, ALU and writeback.
// Revision : 1.0
// ============================================================================
interface alu_seq_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             sbit;
  logic [3:0]       cond;
  logic [3:0]       opcode;
  logic [2:0]       srcontrol;
  logic [15:0]      imvalue;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             out_skip;
  logic             out_err;
  logic             busy;

  modport master (
    output in_valid, in1, in2, sbit, cond, opcode, srcontrol, imvalue, out_ready,
    input  in_ready, out_valid, result, flags, out_skip, out_err, busy
  );

  modport slave (
    input  in_valid, in1, in2, sbit, cond, opcode, srcontrol, imvalue, out_ready,
    output in_ready, out_valid, result, flags, out_skip, out_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pipe
// Brief    : Handshaked ALU with NZCV flag register, condition codes and an
//            iterative shift-add multiplier behind a registered output stage.
// Revision : 1.0
// ============================================================================
module alu_seq_pipe #(
  parameter int         WIDTH      = 32,
  parameter int         MUL_BPC    = 1,
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_pipe_if.slave bus
);
  localparam int c_SH        = $clog2(WIDTH);
  localparam int c_MUL_ITERS = WIDTH / MUL_BPC;
  localparam int c_CW        = $clog2(c_MUL_ITERS + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_MUL_ITERS - 1);

  localparam logic [0:0] c_S_IDLE = 1'b0;
  localparam logic [0:0] c_S_MUL  = 1'b1;

  localparam logic [3:0] c_OP_ADD  = 4'b0000;
  localparam logic [3:0] c_OP_SUB  = 4'b0001;
  localparam logic [3:0] c_OP_MUL  = 4'b0010;
  localparam logic [3:0] c_OP_OR   = 4'b0011;
  localparam logic [3:0] c_OP_AND  = 4'b0100;
  localparam logic [3:0] c_OP_XOR  = 4'b0101;
  localparam logic [3:0] c_OP_MOVN = 4'b0110;
  localparam logic [3:0] c_OP_MOVR = 4'b0111;
  localparam logic [3:0] c_OP_CMP  = 4'b1000;
  localparam logic [3:0] c_OP_NOP  = 4'b1111;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_out_skip;
  logic             r_out_err;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [c_CW-1:0]  r_cnt;
  logic             r_mul_sbit;

  logic               w_in_ready;
  logic               w_busy;
  logic               w_accept;
  logic               w_cond_ok;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [c_SH-1:0]    w_shamt;
  logic [2*WIDTH-1:0] w_rot2;
  logic [WIDTH-1:0]   w_op2;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_fval;
  logic               w_c;
  logic               w_v;
  logic               w_setf;
  logic               w_legal;
  logic [3:0]         w_nzcv;
  logic [WIDTH-1:0]   w_part;
  logic [WIDTH-1:0]   w_acc_nxt;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (w_mul_start) w_state_nxt = c_S_MUL;
      c_S_MUL:  if (r_cnt == c_LAST) w_state_nxt = c_S_IDLE;
      default:  w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      c_S_IDLE: w_in_ready = !r_out_valid || bus.out_ready;
      c_S_MUL:  w_busy     = 1'b1;
      default:  w_in_ready = 1'b0;
    endcase
  end

  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_mul_start = w_accept && w_cond_ok && (bus.opcode == c_OP_MUL);
  assign w_mul_done  = (r_state == c_S_MUL) && (r_cnt == c_LAST);

  // ---------------------------------------------------------- condition
  always_comb begin
    case (bus.cond)
      4'b0001: w_cond_ok = r_flags[2];
      4'b0010: w_cond_ok = !r_flags[2] && (r_flags[3] == r_flags[0]);
      4'b0011: w_cond_ok = !r_flags[2] && (r_flags[3] != r_flags[0]);
      4'b0100: w_cond_ok = (r_flags[3] == r_flags[0]);
      4'b0101: w_cond_ok = (r_flags[3] != r_flags[0]);
      4'b0110: w_cond_ok = !r_flags[2] && r_flags[1];
      4'b0111: w_cond_ok = !r_flags[1];
      4'b1000: w_cond_ok = r_flags[1];
      default: w_cond_ok = 1'b1;
    endcase
  end

  // ------------------------------------------------------------ shifter
  assign w_shamt = bus.imvalue[c_SH+2:3];
  assign w_rot2  = {bus.in2, bus.in2} >> w_shamt;

  always_comb begin
    case (bus.srcontrol)
      3'b001:  w_op2 = bus.in2 >> w_shamt;
      3'b010:  w_op2 = bus.in2 << w_shamt;
      3'b011:  w_op2 = w_rot2[WIDTH-1:0];
      3'b100:  w_op2 = $signed(bus.in2) >>> w_shamt;
      default: w_op2 = bus.in2;
    endcase
  end

  // ---------------------------------------------------------------- ALU
  assign w_add = {1'b0, bus.in1} + {1'b0, w_op2};
  assign w_sub = {1'b0, bus.in1} + {1'b0, ~w_op2} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_res   = '0;
    w_fval  = '0;
    w_c     = r_flags[1];
    w_v     = r_flags[0];
    w_setf  = bus.sbit;
    w_legal = 1'b1;
    case (bus.opcode)
      c_OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (bus.in1[WIDTH-1] == w_op2[WIDTH-1]) && (w_add[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (bus.in1[WIDTH-1] != w_op2[WIDTH-1]) && (w_sub[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      c_OP_MUL:  w_res = '0;
      c_OP_OR:   w_res = bus.in1 | w_op2;
      c_OP_AND:  w_res = bus.in1 & w_op2;
      c_OP_XOR:  w_res = bus.in1 ^ w_op2;
      c_OP_MOVN: w_res = WIDTH'(bus.imvalue);
      c_OP_MOVR: w_res = bus.in1;
      c_OP_CMP: begin
        w_fval = w_sub[WIDTH-1:0];
        w_c    = w_sub[WIDTH];
        w_v    = (bus.in1[WIDTH-1] != w_op2[WIDTH-1]) && (w_sub[WIDTH-1] != bus.in1[WIDTH-1]);
        w_setf = 1'b1;
      end
      c_OP_NOP: w_setf = 1'b0;
      default: begin
        w_setf  = 1'b0;
        w_legal = 1'b0;
      end
    endcase
    // CMP discards its difference, so flags derive from w_fval rather than w_res
    if (bus.opcode != c_OP_CMP) w_fval = w_res;
  end

  assign w_nzcv = {w_fval[WIDTH-1], (w_fval == '0), w_c, w_v};

  // --------------------------------------------------------- multiplier
  always_comb begin
    w_part = '0;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (r_mplier[j]) w_part = w_part + (r_mcand << j);
    end
  end

  assign w_acc_nxt = r_acc + w_part;

  // ------------------------------------------------ result/flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_out_skip  <= 1'b0;
      r_out_err   <= 1'b0;
      r_flags     <= FLAG_RESET;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mul_sbit  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (!w_cond_ok) begin
          r_out_valid <= 1'b1;
          r_result    <= '0;
          r_out_skip  <= 1'b1;
          r_out_err   <= 1'b0;
        end else if (bus.opcode == c_OP_MUL) begin
          r_out_valid <= 1'b0;
          r_out_skip  <= 1'b0;
          r_out_err   <= 1'b0;
          r_mcand     <= bus.in1;
          r_mplier    <= w_op2;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_mul_sbit  <= bus.sbit;
        end else begin
          r_out_valid <= 1'b1;
          r_result    <= w_res;
          r_out_skip  <= 1'b0;
          r_out_err   <= !w_legal;
          if (w_setf) r_flags <= w_nzcv;
        end
      end else if (w_mul_done) begin
        r_out_valid <= 1'b1;
        r_result    <= w_acc_nxt;
        r_out_skip  <= 1'b0;
        r_out_err   <= 1'b0;
        if (r_mul_sbit) r_flags <= {w_acc_nxt[WIDTH-1], (w_acc_nxt == '0), r_flags[1:0]};
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (r_state == c_S_MUL) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << MUL_BPC;
        r_mplier <= r_mplier >> MUL_BPC;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;
  assign bus.out_skip  = r_out_skip;
  assign bus.out_err   = r_out_err;
endmodule
`default_nettype wire
